// File: rtl/alu_cmd_issuer.sv
// Multi-cycle ALU command issuer: 8x8 register file, IDLE/OPER/EXEC/WB sequencing, debug read port.
// Optional res_zero output enabled by defining ALU_ZERO_FLAG_EN.
module alu_cmd_issuer #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_ra,
  input  logic [2:0] cmd_rb,
  input  logic [2:0] cmd_rd,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic [2:0] res_rd,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic       res_zero
`endif
);

  typedef enum logic [1:0] {StIdle, StOper, StExec, StWb} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d, ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic [7:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [7:0]  result_q, result_d;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_data_q, res_data_d;
  logic [2:0]  res_rd_q, res_rd_d;
  logic        rf_we;
  // Entry 0 is reset to zero and never written, so it always reads 8'h00.
  logic [7:0]  rf_q [8];
`ifdef ALU_ZERO_FLAG_EN
  logic        res_zero_q, res_zero_d;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    rd_d        = rd_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    result_d    = result_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    rf_we       = 1'b0;
`ifdef ALU_ZERO_FLAG_EN
    res_zero_d  = res_zero_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          ra_d    = cmd_ra;
          rb_d    = cmd_rb;
          rd_d    = cmd_rd;
          state_d = StOper;
        end
      end
      StOper: begin
        alu_a_d  = rf_q[ra_q];
        alu_b_d  = rf_q[rb_q];
        alu_op_d = op_q;
        state_d  = StExec;
      end
      StExec: begin
        result_d = alu_out;
        state_d  = StWb;
      end
      StWb: begin
        rf_we       = (rd_q != 3'd0);
        res_valid_d = 1'b1;
        res_data_d  = result_q;
        res_rd_d    = rd_q;
`ifdef ALU_ZERO_FLAG_EN
        res_zero_d  = (result_q == 8'h00);
`endif
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 3'd0;
      ra_q        <= 3'd0;
      rb_q        <= 3'd0;
      rd_q        <= 3'd0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_op_q    <= 3'd0;
      result_q    <= 8'h00;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_rd_q    <= 3'd0;
`ifdef ALU_ZERO_FLAG_EN
      res_zero_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rd_q        <= rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
`ifdef ALU_ZERO_FLAG_EN
      res_zero_q  <= res_zero_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q[0] <= 8'h00;
      for (int i = 1; i < 8; i++) rf_q[i] <= RESET_VAL;
    end else if (rf_we) begin
      rf_q[rd_q] <= result_q;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_rd     = res_rd_q;
  assign dbg_data   = rf_q[dbg_addr];
`ifdef ALU_ZERO_FLAG_EN
  assign res_zero   = res_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed table, hand-written multi-cycle sequences and random commands
// checked against a register-file/ALU reference model.
module tb_alu_cmd_issuer;
  localparam logic [7:0] RV = 8'h3C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0, cmd_ra = 3'd0, cmd_rb = 3'd0, cmd_rd = 3'd0;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_opcode;
  logic       res_valid;
  logic [7:0] res_data;
  logic [2:0] res_rd;
  logic [2:0] dbg_addr = 3'd0;
  logic [7:0] dbg_data;
`ifdef ALU_ZERO_FLAG_EN
  logic       res_zero;
`endif

  alu_cmd_issuer #(.RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_ZERO_FLAG_EN
    , .res_zero(res_zero)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_alu(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ~b;
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  // External combinational ALU seen by the DUT
  always_comb alu_out = model_alu(alu_opcode, alu_a, alu_b);

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] ref_rf [8];

  function automatic logic [7:0] ref_rd(input logic [2:0] i);
    return (i == 3'd0) ? 8'h00 : ref_rf[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_rf[i] = RV;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Issue one command from a negedge and follow it through to completion.
  task automatic send(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                      input logic [2:0] rd, input int idle, output logic [7:0] got);
    logic [7:0] a, b, r;
    int w;
    repeat (idle) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
    w = 0;
    while (!cmd_ready && w < 16) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", {31'd0, cmd_ready}, 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      got = 8'hxx;
      return;
    end
    a = ref_rd(ra);
    b = ref_rd(rb);
    r = model_alu(op, a, b);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_oper", {30'd0, cmd_ready, res_valid}, 32'd0);
    @(negedge clk);
    chk("operands", {13'd0, alu_opcode, alu_a, alu_b}, {13'd0, op, a, b});
    chk("busy_exec", {30'd0, cmd_ready, res_valid}, 32'd0);
    @(negedge clk);
    chk("busy_wb", {30'd0, cmd_ready, res_valid}, 32'd0);
    @(negedge clk);
    chk("done", {30'd0, cmd_ready, res_valid}, 32'd3);
    chk("result", {21'd0, res_rd, res_data}, {21'd0, rd, r});
`ifdef ALU_ZERO_FLAG_EN
    chk("res_zero", {31'd0, res_zero}, {31'd0, r == 8'h00});
`endif
    chk("operand_hold", {13'd0, alu_opcode, alu_a, alu_b}, {13'd0, op, a, b});
    if (rd != 3'd0) ref_rf[rd] = r;
    dbg_addr = rd;
    #1;
    chk("dbg_rd", {24'd0, dbg_data}, {24'd0, ref_rd(rd)});
    got = res_data;
  endtask

  typedef struct {
    logic [2:0] op, ra, rb, rd;
    logic [7:0] want;
  } vec_t;
  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] exp_q [$];
    logic [2:0] exprd_q [$];
    int last_acc, n_acc;

    vecs[0] = '{3'd4, 3'd0, 3'd0, 3'd1, 8'hFF};
    vecs[1] = '{3'd0, 3'd1, 3'd1, 3'd2, 8'hFE};
    vecs[2] = '{3'd1, 3'd2, 3'd1, 3'd3, 8'hFF};
    vecs[3] = '{3'd5, 3'd3, 3'd1, 3'd4, 8'h00};
    vecs[4] = '{3'd4, 3'd0, 3'd0, 3'd0, 8'hFF};
    vecs[5] = '{3'd7, 3'd1, 3'd2, 3'd6, 8'h00};
    vecs[6] = '{3'd6, 3'd2, 3'd1, 3'd7, 8'hFE};
    vecs[7] = '{3'd2, 3'd2, 3'd3, 3'd5, 8'hFE};
    vecs[8] = '{3'd3, 3'd4, 3'd2, 3'd5, 8'hFE};
    vecs[9] = '{3'd0, 3'd1, 3'd1, 3'd1, 8'hFE};

    // Asynchronous reset: checked before any clock edge
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_alu", {13'd0, alu_opcode, alu_a, alu_b}, 32'd0);
    chk("rst_res", {20'd0, res_valid, res_rd, res_data}, 32'd0);
`ifdef ALU_ZERO_FLAG_EN
    chk("rst_zero", {31'd0, res_zero}, 32'd0);
`endif
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("rst_rf", {24'd0, dbg_data}, {24'd0, ref_rd(3'(i))});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Directed table, back-to-back so each command reads the previous writeback
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rd, 0, got);
      chk("table", {24'd0, got}, {24'd0, vecs[i].want});
    end
    dbg_addr = 3'd0;
    #1;
    chk("r0_zero", {24'd0, dbg_data}, 32'd0);

    // cmd_valid held high: one acceptance every 4 cycles, results in order
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_rd = 3'd7;
    last_acc = -1;
    n_acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (res_valid) begin
        if (exp_q.size() > 0) begin
          chk("stream_res", {21'd0, res_rd, res_data}, {21'd0, exprd_q[0], exp_q[0]});
          if (exprd_q[0] != 3'd0) ref_rf[exprd_q[0]] = exp_q[0];
          void'(exp_q.pop_front());
          void'(exprd_q.pop_front());
        end else begin
          chk("stream_spurious", 32'd1, 32'd0);
        end
      end
      if (cmd_ready) begin
        if (last_acc >= 0) chk("stream_gap", c - last_acc, 32'd4);
        last_acc = c;
        n_acc++;
        exp_q.push_back(model_alu(cmd_op, ref_rd(cmd_ra), ref_rd(cmd_rb)));
        exprd_q.push_back(cmd_rd);
      end
      @(posedge clk);
      @(negedge clk);
      if (n_acc == 1) begin
        cmd_op = 3'd1; cmd_ra = 3'd7; cmd_rb = 3'd1; cmd_rd = 3'd6;
      end
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
      if (res_valid) begin
        chk("stream_res", {21'd0, res_rd, res_data}, {21'd0, exprd_q[0], exp_q[0]});
        if (exprd_q[0] != 3'd0) ref_rf[exprd_q[0]] = exp_q[0];
        void'(exp_q.pop_front());
        void'(exprd_q.pop_front());
      end
      @(negedge clk);
    end
    chk("stream_count", n_acc, 32'd5);
    chk("stream_drain", exp_q.size(), 32'd0);

    // Reset during EXEC aborts the command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_rd = 3'd5;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_alu", {13'd0, alu_opcode, alu_a, alu_b}, 32'd0);
    chk("abort_res", {20'd0, res_valid, res_rd, res_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_rel", {31'd0, cmd_ready}, 32'd1);
    begin
      int pulses = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (res_valid) pulses++;
      end
      chk("abort_no_pulse", pulses, 32'd0);
    end
    dbg_addr = 3'd5;
    #1;
    chk("abort_r5", {24'd0, dbg_data}, {24'd0, RV});

    // Random commands against the reference model
    for (int i = 0; i < 200; i++) begin
      send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), got);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("final_rf", {24'd0, dbg_data}, {24'd0, ref_rd(3'(i))});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter: RESET_VAL, default 8'h00, reset value of register entries r1..r7.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: cmd_valid  input  1  command present.
REQ-005 Port: cmd_ready  output  1  issuer can accept a command.
REQ-006 Port: cmd_op  input  3  ALU opcode to issue (000 add, 001 sub, 010 and, 011 or, 100 not-b, 101 xor, 110 xnor, 111 reserved).
REQ-007 Port: cmd_ra, cmd_rb, cmd_rd  input  3 each  source A, source B and destination register indices.
REQ-008 Port: alu_a, alu_b  output  8 each  registered operands driven to the ALU.
REQ-009 Port: alu_opcode  output  3  registered opcode driven to the ALU.
REQ-010 Port: alu_out  input  8  combinational ALU result.
REQ-011 Port: res_valid  output  1  one-cycle pulse marking a completed command.
REQ-012 Port: res_data, res_rd  output  8 / 3  result value and its destination index, held until the next completion.
REQ-013 Port: dbg_addr  input  3 / dbg_data  output  8  combinational register-file read port for test.

Function
REQ-014 The block SHALL hold an 8 x 8-bit register file, with r0 reading 8'h00 at all times and ignoring writes.
REQ-015 The FSM SHALL have states IDLE, OPER, EXEC and WB.
REQ-016 cmd_ready SHALL be 1 only in IDLE.
REQ-017 A command SHALL be accepted when cmd_valid and cmd_ready are both 1 at a clock edge; op, ra, rb and rd SHALL then be captured and the FSM SHALL go IDLE->OPER.
REQ-018 In OPER, the block SHALL register alu_a=r[ra], alu_b=r[rb] and alu_opcode=op, then go to EXEC.
REQ-019 In EXEC, the block SHALL capture alu_out into an internal result register, then go to WB.
REQ-020 In WB, the block SHALL write the result to r[rd] (unless rd=0), pulse res_valid for exactly one cycle, update res_data and res_rd, and return to IDLE.
REQ-021 Latency: for a command accepted at edge N, res_valid SHALL be high in the cycle after edge N+3; throughput SHALL be one command per 4 cycles.
REQ-022 cmd_valid while the block is busy SHALL NOT be accepted; the command SHALL be taken on the first IDLE edge at which it is still presented.
REQ-023 Read-after-write: a command accepted immediately after a completion SHALL read the written value.
REQ-024 ra=rb, rd=ra and rd=rb SHALL all be legal; operands SHALL be read before writeback.
REQ-025 Opcode 111 SHALL be issued unchanged, and whatever alu_out returns (8'h00) SHALL be written.
REQ-026 Arithmetic SHALL wrap modulo 256; no carry or overflow is reported.
REQ-027 alu_a, alu_b and alu_opcode SHALL hold their last values outside OPER.

Reset
REQ-028 While rst=1, regardless of clk: state=IDLE; r1..r7=RESET_VAL; alu_a=alu_b=8'h00; alu_opcode=3'b000; res_valid=0; res_data=8'h00; res_rd=3'b000.
REQ-029 Reset asserted mid-command SHALL abort it with no writeback and no res_valid pulse.
REQ-030 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 With macro ALU_ZERO_FLAG_EN defined, the block SHALL add output res_zero (1 bit), registered in WB as (result==8'h00), held with res_data and reset to 0.
REQ-032 Without ALU_ZERO_FLAG_EN, the block SHALL have no res_zero port, and all other behaviour SHALL be identical.

Verification
REQ-033 After reset, send op=100 ra=0 rb=0 rd=1 -> res_valid 4 cycles after acceptance, res_data=8'hFF, res_rd=1, dbg r1=8'hFF.
REQ-034 Next, send op=000 ra=1 rb=1 rd=2 -> r2=8'hFE; then op=001 ra=2 rb=1 rd=3 -> r3=8'hFF (wrap); then op=101 ra=3 rb=1 rd=4 -> r4=8'h00, res_zero=1 when ALU_ZERO_FLAG_EN is defined.
REQ-035 Send op=100 rb=0 rd=0 -> res_data=8'hFF, res_rd=0, dbg r0 still 8'h00.
REQ-036 Hold cmd_valid high continuously with two different commands -> cmd_ready low during OPER/EXEC/WB, exactly one acceptance per 4 cycles, results in order.
REQ-037 Assert rst during EXEC of op=100 rd=5 -> no res_valid pulse, r5=RESET_VAL, cmd_ready=1 after release.
REQ-038 Send op=111 ra=1 rb=2 rd=6 -> alu_opcode=3'b111, r6=8'h00.
